// File: rtl/accum_datapath_pkg.sv
// accum_datapath_pkg: tap count and tap-index type shared with the sequencing controller
package accum_datapath_pkg;
  localparam int NUM_TAPS = 4;
  typedef logic [1:0] tap_idx_t;
endpackage

// File: rtl/accum_datapath_sat_add.sv
// sat_add: signed add of an AW-wide and a BW-wide operand, saturated to the AW range
module sat_add #(
  parameter int AW = 18,
  parameter int BW = AW
) (
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic signed [AW-1:0] sum,
  output logic                 sat
);
  localparam int EW = (AW > BW ? AW : BW) + 1;
  localparam logic signed [EW-1:0] MAX = {{(EW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN = ~MAX;
  logic signed [EW-1:0] wide;
  assign wide = EW'(a) + EW'(b);
  assign sat  = (wide > MAX) || (wide < MIN);
  assign sum  = wide > MAX ? AW'(MAX) : wide < MIN ? AW'(MIN) : AW'(wide);
endmodule

// File: rtl/accum_datapath.sv
// accum_datapath: 4-tap multiply-accumulate with saturation, frame publish and sequence checking
module accum_datapath
  import accum_datapath_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int AW = DW + CW + 2
) (
  input  logic                     ph1,
  input  logic                     reset_n,
  input  logic                     en,
  input  tap_idx_t                 mux_sel,
  input  logic                     clear_accum,
  input  logic                     load_samples,
  input  logic [NUM_TAPS*DW-1:0]   x_in,
  input  logic                     coef_we,
  input  tap_idx_t                 coef_addr,
  input  logic signed [CW-1:0]     coef_wdata,
  input  logic                     ovf_clr,
  output logic signed [AW-1:0]     result,
  output logic                     result_valid,
  output logic                     ovf,
  output logic                     seq_err
);
  logic signed [DW-1:0]    samples [NUM_TAPS];
  logic signed [CW-1:0]    coefs   [NUM_TAPS];
  logic signed [AW-1:0]    accum, sum;
  logic signed [DW+CW-1:0] product;
  logic                    sat;
  tap_idx_t                exp_idx;

  assign product = samples[mux_sel] * coefs[mux_sel];

  sat_add #(.AW(AW), .BW(DW+CW)) u_sat (
    .a   (accum),
    .b   (product),
    .sum (sum),
    .sat (sat)
  );

  always_ff @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        samples[k] <= '0;
        coefs[k]   <= '0;
      end
      accum        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      ovf          <= 1'b0;
      seq_err      <= 1'b0;
      exp_idx      <= '0;
    end else begin
      if (load_samples)
        for (int k = 0; k < NUM_TAPS; k++) samples[k] <= x_in[k*DW +: DW];
      if (coef_we) coefs[coef_addr] <= coef_wdata;
      result_valid <= en && clear_accum;
      seq_err      <= en && (mux_sel != exp_idx);
      ovf          <= (en && sat) ? 1'b1 : ovf_clr ? 1'b0 : ovf;
      if (en) begin
        accum   <= clear_accum ? '0 : sum;
        exp_idx <= clear_accum ? '0 : tap_idx_t'(mux_sel + 2'd1);
        if (clear_accum) result <= sum;
      end
    end
  end
endmodule

// File: tb/tb_accum_datapath.sv
// tb_accum_datapath: directed and randomized checks of accum_datapath against an integer model
module tb_accum_datapath;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int AW = 10;
  localparam int AMAX = 2 ** (AW - 1) - 1;
  localparam int AMIN = -(2 ** (AW - 1));

  logic                 ph1 = 1'b0;
  logic                 reset_n, en, clear_accum, load_samples, coef_we, ovf_clr;
  logic [1:0]           mux_sel, coef_addr;
  logic [4*DW-1:0]      x_in;
  logic signed [CW-1:0] coef_wdata;
  logic signed [AW-1:0] result;
  logic                 result_valid, ovf, seq_err;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  int m_samp[4], m_coef[4];
  int m_acc, m_res, m_rv, m_ovf, m_err, m_exp;
  int m_raw, m_sum;

  accum_datapath #(.DW(DW), .CW(CW), .AW(AW)) dut (
    .ph1          (ph1),
    .reset_n      (reset_n),
    .en           (en),
    .mux_sel      (mux_sel),
    .clear_accum  (clear_accum),
    .load_samples (load_samples),
    .x_in         (x_in),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .ovf_clr      (ovf_clr),
    .result       (result),
    .result_valid (result_valid),
    .ovf          (ovf),
    .seq_err      (seq_err)
  );

  always #5 ph1 = ~ph1;

  function automatic int clamp(input int v);
    return v > AMAX ? AMAX : v < AMIN ? AMIN : v;
  endfunction

  // Reference: plain integer arithmetic, "old" operands read before this edge's writes
  always @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) begin
        m_samp[k] = 0;
        m_coef[k] = 0;
      end
      m_acc = 0; m_res = 0; m_rv = 0; m_ovf = 0; m_err = 0; m_exp = 0;
    end else begin
      m_raw = m_acc + m_samp[mux_sel] * m_coef[mux_sel];
      m_sum = clamp(m_raw);
      m_rv  = int'(en && clear_accum);
      m_err = int'(en && (int'(mux_sel) != m_exp));
      if (en && m_sum != m_raw) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (en) begin
        if (clear_accum) m_res = m_sum;
        m_acc = clear_accum ? 0 : m_sum;
        m_exp = clear_accum ? 0 : (int'(mux_sel) + 1) % 4;
      end
      if (load_samples)
        for (int k = 0; k < 4; k++) m_samp[k] = int'($signed(x_in[k*DW +: DW]));
      if (coef_we) m_coef[coef_addr] = int'(coef_wdata);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge ph1) begin
    if (cmp_on) begin
      chk("model_result", int'(result), m_res);
      chk("model_result_valid", int'(result_valid), m_rv);
      chk("model_ovf", int'(ovf), m_ovf);
      chk("model_seq_err", int'(seq_err), m_err);
    end
  end

  task automatic cyc();
    @(posedge ph1);
    #1;
  endtask

  task automatic tap(input logic [1:0] s, input logic c);
    en = 1'b1; mux_sel = s; clear_accum = c;
    cyc();
    en = 1'b0; clear_accum = 1'b0;
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
    int c[4];
    c = '{c0, c1, c2, c3};
    coef_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      coef_addr = 2'(k); coef_wdata = CW'(c[k]);
      cyc();
    end
    coef_we = 1'b0;
  endtask

  task automatic load_x(input int a, input int b, input int c, input int d);
    x_in = {DW'(d), DW'(c), DW'(b), DW'(a)};
    load_samples = 1'b1;
    cyc();
    load_samples = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; clear_accum = 1'b0; load_samples = 1'b0; coef_we = 1'b0;
    ovf_clr = 1'b0; mux_sel = '0; coef_addr = '0; x_in = '0; coef_wdata = '0;
    cyc(); cyc();
    cmp_on = 1'b1;
    chk("reset_result", int'(result), 0);
    chk("reset_valid", int'(result_valid), 0);
    chk("reset_ovf", int'(ovf), 0);
    reset_n = 1'b1;
    cyc();

    // basic frame
    set_coefs(1, 2, 3, 4);
    load_x(10, 20, 30, 40);
    tap(0, 0); tap(1, 0); tap(2, 0);
    chk("frame_no_valid_early", int'(result_valid), 0);
    tap(3, 1);
    chk("frame_result", int'(result), 300);
    chk("frame_valid", int'(result_valid), 1);
    cyc();
    chk("frame_valid_pulse", int'(result_valid), 0);
    chk("frame_result_hold", int'(result), 300);

    // saturation and sticky overflow
    chk("ovf_before", int'(ovf), 0);
    set_coefs(127, 127, 127, 127);
    load_x(127, 127, 127, 127);
    tap(0, 0); tap(1, 0); tap(2, 0); tap(3, 1);
    chk("sat_result", int'(result), 511);
    chk("sat_ovf", int'(ovf), 1);
    cyc(); cyc(); cyc();
    chk("ovf_sticky", int'(ovf), 1);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    chk("ovf_cleared", int'(ovf), 0);
    ovf_clr = 1'b1; tap(0, 0); ovf_clr = 1'b0;
    chk("ovf_set_wins_clr", int'(ovf), 1);
    tap(1, 0); tap(2, 0); tap(3, 1);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;

    // sequence error
    set_coefs(1, 2, 3, 4);
    load_x(10, 20, 30, 40);
    tap(0, 0);
    chk("seq_ok0", int'(seq_err), 0);
    tap(2, 0);
    chk("seq_err_pulse", int'(seq_err), 1);
    tap(3, 1);
    chk("seq_resync3", int'(seq_err), 0);
    chk("seq_result", int'(result), 260);
    tap(0, 1);
    chk("seq_resync0", int'(seq_err), 0);
    chk("seq_result0", int'(result), 10);

    // en low mid-frame with clear_accum high
    tap(0, 0); tap(1, 0);
    mux_sel = 2'd2; clear_accum = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_no_valid", int'(result_valid), 0);
      chk("hold_result", int'(result), 10);
    end
    clear_accum = 1'b0;
    tap(2, 0); tap(3, 1);
    chk("hold_accum_kept", int'(result), 300);

    // reset mid-frame
    set_coefs(5, 5, 5, 5);
    load_x(1, 1, 1, 1);
    tap(0, 0); tap(1, 0);
    reset_n = 1'b0;
    cyc();
    chk("midrst_result", int'(result), 0);
    chk("midrst_valid", int'(result_valid), 0);
    reset_n = 1'b1;
    set_coefs(5, 5, 5, 5);
    load_x(1, 1, 1, 1);
    chk("midrst_no_stale", int'(result_valid), 0);
    tap(0, 0); tap(1, 0); tap(2, 0); tap(3, 1);
    chk("midrst_result20", int'(result), 20);
    chk("midrst_valid20", int'(result_valid), 1);

    // coefficient write during its own tap
    set_coefs(1, 2, 3, 4);
    load_x(10, 20, 10, 40);
    tap(0, 0); tap(1, 0);
    coef_we = 1'b1; coef_addr = 2'd2; coef_wdata = 8'sd9;
    tap(2, 0);
    coef_we = 1'b0;
    tap(3, 1);
    chk("coefwr_old", int'(result), 240);
    tap(0, 0); tap(1, 0); tap(2, 0); tap(3, 1);
    chk("coefwr_new", int'(result), 300);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit big;
      big = $urandom_range(0, 3) == 0;
      en = $urandom_range(0, 3) != 0;
      mux_sel = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'(m_exp);
      clear_accum = (mux_sel == 2'd3) || ($urandom_range(0, 15) == 0);
      load_samples = $urandom_range(0, 5) == 0;
      for (int k = 0; k < 4; k++)
        x_in[k*DW +: DW] = big ? DW'($urandom) : DW'(int'($urandom_range(0, 14)) - 7);
      coef_we = $urandom_range(0, 7) == 0;
      coef_addr = 2'($urandom);
      coef_wdata = big ? CW'($urandom) : CW'(int'($urandom_range(0, 14)) - 7);
      ovf_clr = $urandom_range(0, 9) == 0;
      reset_n = $urandom_range(0, 199) != 0;
      cyc();
    end
    reset_n = 1'b1; en = 1'b0; load_samples = 1'b0; coef_we = 1'b0; ovf_clr = 1'b0;
    cyc();
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
